// File: rtl/riscv_dmem_pkg.sv
// Shared definitions for the data-memory arbiter slice.
// Holds the default address/data widths, the port-id encoding stored in the
// response register, and the width of the m1 starvation counter.
package riscv_dmem_pkg;

  localparam int DMEM_AW = 7;
  localparam int DMEM_DW = 32;

  // Port ids as captured in resp_port.
  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_ACC  = 1'b1;

  // The starvation counter is 3 bits wide, so STARVE_MAX must be <= 7.
  localparam int STARVE_CNT_W = 3;

endpackage

// File: rtl/riscv_dmem_starve_cnt.sv
// Starvation counter for the low-priority requester (m1).
// Counts consecutive cycles in which m1 requests but is not granted,
// saturating at STARVE_MAX. Any grant or any idle cycle clears it.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   req         - m1 request this cycle
//   gnt         - m1 grant this cycle
//   force_win   - m1 must win this cycle (count reached STARVE_MAX while requesting)
module riscv_dmem_starve_cnt
  import riscv_dmem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic gnt,
  output logic force_win
);

  localparam logic [STARVE_CNT_W-1:0] MAX_C = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!req || gnt) begin
      cnt <= '0;
    end else if (cnt != MAX_C) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Combinational from the registered count, so the forced grant lands in
  // the same cycle the count reaches the limit.
  assign force_win = req && (cnt == MAX_C);

endmodule

// File: rtl/riscv_dmem_arbiter.sv
// Two-port arbiter in front of a single-port data RAM.
// m0 (core LSU) has default priority; m1 (anomaly-detection accelerator) is
// guaranteed a win after STARVE_MAX consecutive losses. The RAM sits outside
// this block and has a 1-cycle registered read; writes return the written
// data (write-through), so every accepted access gets exactly one response
// one cycle later on the port that issued it.
//
// Handshake: a transfer happens in any cycle where mX_req=1 and mX_gnt=1.
// Grants are combinational from the requests in the same cycle. A requester
// that is not granted must hold its payload stable; nothing is buffered here.
// mX_rvalid pulses for one cycle, one cycle after the transfer, and mX_rdata
// is valid only while mX_rvalid=1 (0 otherwise).
//
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   m0_req/we/addr/wdata          - core request
//   m0_gnt, m0_rvalid, m0_rdata   - core grant and response
//   m1_*                          - same for the accelerator
//   ram_en/we/addr/wdata          - RAM command (zeros when idle)
//   ram_rdata                     - RAM read data, one cycle after ram_en
module riscv_dmem_arbiter
  import riscv_dmem_pkg::*;
#(
  parameter int AW         = DMEM_AW,
  parameter int DW         = DMEM_DW,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  logic force_m1;
  logic resp_valid;
  logic resp_port;

  riscv_dmem_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (m1_req),
    .gnt      (m1_gnt),
    .force_win(force_m1)
  );

  // m1 wins when m0 is idle or when it has been starved long enough.
  // Gating with rst_n keeps the RAM quiet while reset is held.
  assign m1_gnt = rst_n && m1_req && (force_m1 || !m0_req);
  assign m0_gnt = rst_n && m0_req && !m1_gnt;
  assign ram_en = m0_gnt || m1_gnt;

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (m1_gnt) begin
      ram_we    = m1_we;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
    end else if (m0_gnt) begin
      ram_we    = m0_we;
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
    end
  end

  // Remember who was served so the RAM's next-cycle data is steered back
  // to the right requester. Reset drops any response still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_port  <= PORT_CORE;
    end else begin
      resp_valid <= ram_en;
      resp_port  <= m1_gnt ? PORT_ACC : PORT_CORE;
    end
  end

  assign m0_rvalid = resp_valid && (resp_port == PORT_CORE);
  assign m1_rvalid = resp_valid && (resp_port == PORT_ACC);
  assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
  assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

endmodule
